// File: rtl/reg32_serial_rx.sv
// reg32_serial_rx: serial-to-parallel receiver for the 32-bit shifting-register link.
// Rebuilds words from the serial stream of a reg_32 chain and honours the transmitter's
// shift direction, which is latched with the first bit of every word. Each finished word is
// presented with a valid/ready handshake. A sticky flag records bits dropped while a word
// was still pending.
//
// Optional feature: define PARITY_CHECK_EN to add a trailing even-parity bit to each frame.
// That bit is checked and reported on PARITY_ERR. When the macro is undefined, PARITY_ERR
// is tied to 0.
//
// Ports:
//   CLK        rising-edge clock
//   RESET_N    synchronous reset, active low (overrides ENB)
//   ENB        block enable; 0 freezes all state
//   DIR        1 = LSB first (right shift), 0 = MSB first (left shift)
//   S_IN       serial data bit, qualified by BIT_VALID
//   BIT_VALID  one bit per CLK while high
//   WORD_READY consumer accepts the presented word
//   D_OUT      reconstructed word, stable while WORD_VALID=1
//   WORD_VALID D_OUT holds a complete word
//   BIT_CNT    bits collected in the current frame
//   OVERRUN    sticky: a bit was dropped while a word was pending
//   PARITY_ERR parity mismatch on the presented word
module reg32_serial_rx #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic             BIT_VALID,
  input  logic             WORD_READY,
  output logic [WIDTH-1:0] D_OUT,
  output logic             WORD_VALID,
  output logic [CNT_W-1:0] BIT_CNT,
  output logic             OVERRUN,
  output logic             PARITY_ERR
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             overrun_q, overrun_d;

  logic             hs, accept, first, last, dir_eff;
  logic [CNT_W-1:0] cnt_eff;
  logic [WIDTH-1:0] shifted;

`ifdef PARITY_CHECK_EN
  logic par_q, par_d, par_eff;
  logic perr_q, perr_d;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    overrun_d = overrun_q;
    dir_eff   = dir_q;
    cnt_eff   = cnt_q;
    last      = 1'b0;
    shifted   = shift_q;
`ifdef PARITY_CHECK_EN
    par_d     = par_q;
    perr_d    = perr_q;
    par_eff   = par_q;
`endif

    hs     = ENB && (state_q == StFull) && WORD_READY;
    // In FULL, a bit is only taken if the pending word is consumed on the same edge.
    accept = ENB && BIT_VALID && ((state_q != StFull) || WORD_READY);
    // Any accepted bit outside SHIFT opens a new frame.
    first  = (state_q != StShift);

    if (hs) begin
      state_d = StIdle;
      cnt_d   = '0;
`ifdef PARITY_CHECK_EN
      perr_d  = 1'b0;
`endif
    end

    if (ENB && BIT_VALID && (state_q == StFull) && !WORD_READY) begin
      overrun_d = 1'b1;
    end

    if (accept) begin
      dir_eff = first ? DIR : dir_q;
      cnt_eff = first ? '0 : cnt_q;
      last    = (cnt_eff == CNT_W'(FRAME - 1));
      shifted = dir_eff ? {S_IN, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], S_IN};
      dir_d   = dir_eff;
      cnt_d   = cnt_eff + CNT_W'(1);
      state_d = last ? StFull : StShift;
`ifdef PARITY_CHECK_EN
      par_eff = first ? 1'b0 : par_q;
      if (last) begin
        // Trailing parity bit: data is already complete in the shadow register.
        dout_d = shift_q;
        perr_d = par_eff ^ S_IN;
      end else begin
        shift_d = shifted;
        par_d   = par_eff ^ S_IN;
      end
`else
      shift_d = shifted;
      if (last) dout_d = shifted;
`endif
    end
  end

  assign D_OUT      = dout_q;
  assign WORD_VALID = (state_q == StFull);
  assign BIT_CNT    = cnt_q;
  assign OVERRUN    = overrun_q;
`ifdef PARITY_CHECK_EN
  assign PARITY_ERR = perr_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule
